// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage, decode and the program loader.
package if_pkg;

    // Default geometry shared with decode and the UART loader
    localparam int unsigned IF_DEF_DATA_W = 32;
    localparam int unsigned IF_DEF_DEPTH  = 16;

    // Fetch FSM state encoding
    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_READ = 2'd1;
    localparam logic [1:0] IF_OUT  = 2'd2;

endpackage : if_pkg

// File: rtl/if_prog_mem.sv
// Program memory: one write port, one synchronous read port, read-before-write.
module if_prog_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Registered read; non-blocking update gives old data on a same-address write
    always_ff @(posedge clk) begin
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule : if_prog_mem

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: loadable program memory, PC, fetch FSM and IF/ID register.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned DATA_W   = IF_DEF_DATA_W,
    parameter int unsigned DEPTH    = IF_DEF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_valid,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_instr,
    input  logic              i_flush,
    input  logic [ADDR_W:0]   i_redirect_pc,
    input  logic              i_id_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W:0]   o_pc,
    output logic [ADDR_W:0]   o_avail,
    output logic              o_done
);

    localparam int unsigned PC_W     = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_PC = PC_W'(DEPTH);
    localparam logic [ADDR_W:0] RST_PC   = PC_W'(RESET_PC);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W:0]   avail_q, avail_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W:0]   opc_q, opc_d;
    logic              done_q, done_d;

    logic              rd_en_c;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   pc_inc_c;
    logic [ADDR_W:0]   load_top_c;
    logic              xfer_c;

    if_prog_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (i_load_valid),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_instr),
        .i_re    (rd_en_c),
        .i_raddr (pc_d[ADDR_W-1:0]),
        .o_rdata (rd_data)
    );

    // Next-state, PC, IF/ID and load high-water computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        rd_en_c    = 1'b0;
        xfer_c     = valid_q && i_id_ready;
        pc_inc_c   = pc_q + PC_W'(1);
        load_top_c = PC_W'(i_load_addr) + PC_W'(1);

        case (state_q)
            IF_IDLE: begin
                if ((pc_q < avail_q) && (pc_q < DEPTH_PC)) begin
                    state_d = IF_READ;
                    rd_en_c = 1'b1;
                end
            end
            IF_READ: begin
                state_d = IF_OUT;
                valid_d = 1'b1;
                instr_d = rd_data;
                opc_d   = pc_q;
            end
            IF_OUT: begin
                if (xfer_c) begin
                    pc_d    = pc_inc_c;
                    valid_d = 1'b0;
                    if (pc_inc_c < avail_q) begin
                        state_d = IF_READ;
                        rd_en_c = 1'b1;
                    end else begin
                        state_d = IF_IDLE;
                    end
                end
            end
            default: begin
                state_d = IF_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Flush overrides everything; a concurrent transfer still leaves decode
        if (i_flush) begin
            state_d = IF_IDLE;
            valid_d = 1'b0;
            pc_d    = i_redirect_pc;
            rd_en_c = 1'b0;
        end

        avail_d = avail_q;
        if (i_load_valid && (load_top_c > avail_q)) begin
            avail_d = load_top_c;
        end

        done_d = (pc_d >= DEPTH_PC);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RST_PC;
            avail_q <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            avail_q <= avail_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            done_q  <= done_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_instruction = instr_q;
    assign o_pc          = opc_q;
    assign o_avail       = avail_q;
    assign o_done        = done_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DATA_W=32, DEPTH=16).
module tb_instr_fetch_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              i_load_valid;
    logic [ADDR_W-1:0] i_load_addr;
    logic [DATA_W-1:0] i_load_instr;
    logic              i_flush;
    logic [ADDR_W:0]   i_redirect_pc;
    logic              i_id_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_instruction;
    logic [ADDR_W:0]   o_pc;
    logic [ADDR_W:0]   o_avail;
    logic              o_done;

    int vectors = 0;
    int errors  = 0;

    instr_fetch_unit #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_load_valid  (i_load_valid),
        .i_load_addr   (i_load_addr),
        .i_load_instr  (i_load_instr),
        .i_flush       (i_flush),
        .i_redirect_pc (i_redirect_pc),
        .i_id_ready    (i_id_ready),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_avail       (o_avail),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] ins, input logic [4:0] pc);
        check({tag, ".valid"}, 64'(o_valid), 64'(v));
        check({tag, ".instr"}, 64'(o_instruction), 64'(ins));
        check({tag, ".pc"}, 64'(o_pc), 64'(pc));
    endtask

    task automatic flush_to(input logic [4:0] target);
        i_flush = 1'b1;
        i_redirect_pc = target;
        tick();
        i_flush = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_instr [4];
        int k;
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33; exp_instr[3] = 32'h44;

        rst = 1'b0; i_load_valid = 1'b0; i_load_addr = '0; i_load_instr = '0;
        i_flush = 1'b0; i_redirect_pc = '0; i_id_ready = 1'b0;
        #2;
        check_out("reset", 1'b0, 32'h0, 5'd0);
        check("reset.avail", 64'(o_avail), 64'd0);
        check("reset.done", 64'(o_done), 64'd0);
        #5 rst = 1'b1;
        tick();

        // Load 0..3 while decode is always ready: outputs every other cycle
        i_id_ready = 1'b1;
        k = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            i_load_valid = (cyc <= 4);
            i_load_addr  = ADDR_W'(cyc - 1);
            i_load_instr = exp_instr[(cyc - 1) % 4];
            tick();
            if (cyc == 3 || cyc == 5 || cyc == 7 || cyc == 9) begin
                check_out("stream", 1'b1, exp_instr[k], 5'(k));
                k++;
            end else begin
                check("stream.idle", 64'(o_valid), 64'd0);
            end
        end
        i_load_valid = 1'b0;
        check("stream.count", 64'(k), 64'd4);
        check("stream.avail", 64'(o_avail), 64'd4);
        check("stream.done", 64'(o_done), 64'd0);

        // Back-pressure on 0x22
        i_id_ready = 1'b0;
        flush_to(5'd0);
        tick();
        tick();
        check_out("bp.first", 1'b1, 32'h11, 5'd0);
        i_id_ready = 1'b1; tick(); i_id_ready = 1'b0;
        check("bp.xfer0", 64'(o_valid), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_out("bp.hold", 1'b1, 32'h22, 5'd1);
            tick();
        end
        check_out("bp.hold", 1'b1, 32'h22, 5'd1);
        i_id_ready = 1'b1; tick(); i_id_ready = 1'b0;
        check("bp.xfer1", 64'(o_valid), 64'd0);
        tick();
        check_out("bp.next", 1'b1, 32'h33, 5'd2);
        i_id_ready = 1'b1; tick(); i_id_ready = 1'b0;
        tick();
        check_out("bp.last", 1'b1, 32'h44, 5'd3);

        // Flush while 0x44 is held
        flush_to(5'd1);
        check("flush.valid", 64'(o_valid), 64'd0);
        tick();
        check("flush.read", 64'(o_valid), 64'd0);
        tick();
        check_out("flush.redir", 1'b1, 32'h22, 5'd1);

        // Flush coincident with a transfer takes the redirect, not pc+1
        i_id_ready = 1'b1;
        flush_to(5'd3);
        i_id_ready = 1'b0;
        check("fx.valid", 64'(o_valid), 64'd0);
        tick();
        tick();
        check_out("fx.redir", 1'b1, 32'h44, 5'd3);
        i_id_ready = 1'b1;
        tick();
        check("fx.end", 64'(o_valid), 64'd0);

        // Redirect past the loaded region waits for a late load
        flush_to(5'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late.wait", 64'(o_valid), 64'd0);
        end
        i_load_valid = 1'b1; i_load_addr = 4'd6; i_load_instr = 32'h77;
        tick();
        i_load_valid = 1'b0;
        check("late.avail", 64'(o_avail), 64'd7);
        check("late.novalid", 64'(o_valid), 64'd0);
        tick();
        check("late.read", 64'(o_valid), 64'd0);
        tick();
        check_out("late.out", 1'b1, 32'h77, 5'd6);
        tick();
        check("late.end", 64'(o_valid), 64'd0);
        check("late.done", 64'(o_done), 64'd0);

        // Redirect beyond memory: done with no fetch; then fill and drain
        flush_to(5'd16);
        check("beyond.done", 64'(o_done), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            i_load_valid = 1'b1; i_load_addr = ADDR_W'(i); i_load_instr = 32'h100 + 32'(i);
            tick();
            check("fill.novalid", 64'(o_valid), 64'd0);
        end
        i_load_addr = 4'd15; i_load_instr = 32'h10F;
        tick();
        i_load_valid = 1'b0;
        check("fill.avail_sat", 64'(o_avail), 64'd16);
        flush_to(5'd0);
        check("drain.done0", 64'(o_done), 64'd0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_valid) begin
                check("drain.instr", 64'(o_instruction), 64'(32'h100 + 32'(k)));
                check("drain.pc", 64'(o_pc), 64'(k));
                k++;
            end
        end
        check("drain.count", 64'(k), 64'd16);
        check("drain.done", 64'(o_done), 64'd1);
        check("drain.valid", 64'(o_valid), 64'd0);
        flush_to(5'd0);
        check("restart.done", 64'(o_done), 64'd0);
        tick();
        tick();
        check_out("restart.first", 1'b1, 32'h100, 5'd0);

        // Asynchronous reset while a read is in flight
        tick();
        #1 rst = 1'b0;
        #1;
        check_out("arst", 1'b0, 32'h0, 5'd0);
        check("arst.avail", 64'(o_avail), 64'd0);
        check("arst.done", 64'(o_done), 64'd0);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst.idle", 64'(o_valid), 64'd0);
        end
        i_load_valid = 1'b1; i_load_addr = 4'd0; i_load_instr = 32'h55;
        tick();
        i_load_valid = 1'b0;
        check("arst.avail1", 64'(o_avail), 64'd1);
        tick();
        tick();
        check_out("arst.fetch", 1'b1, 32'h55, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_instr_fetch_unit
